// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types and defaults for the load/store memory-port arbiter.
//   mem_cmd_t     : memory command encoding, identical to the iu load/store ops
//   arb_state_t   : arbiter sequencer states
//   ADDR_W_DEF    : default memory address width
//   DATA_W_DEF    : default memory data width
//   is_active_cmd : true for a load or store; 2'b11 counts as idle
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } mem_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } arb_state_t;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 8;

    function automatic logic is_active_cmd(input logic [1:0] cmd);
        return (cmd == MEM_LOAD) || (cmd == MEM_STORE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selection. The search starts at rr_ptr_i+1
// (mod NUM_REQ) and wraps, so the last-served requester has lowest priority.
// Ports:
//   req_i      in  NUM_REQ : active-request vector
//   rr_ptr_i   in  IDX_W   : index of the requester served last
//   grant_o    out IDX_W   : chosen index (0 when no request)
//   any_req_o  out 1       : at least one request is active
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               any_req_o
);

    always_comb begin
        int idx;
        grant_o = '0;
        idx     = 0;
        // Walk from the farthest offset to the nearest so the nearest
        // requesting index after rr_ptr_i is the one that remains.
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(rr_ptr_i) + off) % NUM_REQ;
            if (req_i[idx]) begin
                grant_o = IDX_W'(idx);
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one load/store memory port among NUM_REQ instruction units using a
// round-robin IDLE -> BUSY -> DONE sequencer. The granted command is latched
// on the IDLE->BUSY edge and held on the memory port for the whole BUSY phase;
// DONE issues a one-cycle req_done pulse to the granted requester.
//
// Build option: define MEM_ARB_TIMEOUT_EN to abort a BUSY phase after
// TIMEOUT_CYC cycles without mem_done (req_rdata forced to 0, sticky
// timeout_err). Without it BUSY waits indefinitely and timeout_err is 0.
//
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   req_cmd       : 2 bits per requester (00 idle, 01 load, 10 store, 11 idle)
//   req_addr      : ADDR_W bits per requester
//   req_wdata     : DATA_W bits per requester
//   req_done      : one-hot completion pulse (DONE state)
//   req_rdata     : broadcast load data, valid with req_done
//   mem_cmd/addr/wdata : memory port, command non-idle only in BUSY
//   mem_rdata, mem_done : memory response
//   grant_valid   : transaction in progress (BUSY)
//   grant_id      : requester currently or last granted
//   timeout_err   : sticky timeout flag
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2*NUM_REQ-1:0]        req_cmd,
    input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
    input  logic [DATA_W*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_done,
    output logic [DATA_W-1:0]           req_rdata,
    output logic [1:0]                  mem_cmd,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_done,
    output logic                        grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("mem_port_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    // Per-requester views of the packed request buses.
    logic [1:0]        cmd_arr   [NUM_REQ];
    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0] active;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cmd_arr[i]   = req_cmd[2*i +: 2];
            addr_arr[i]  = req_addr[ADDR_W*i +: ADDR_W];
            wdata_arr[i] = req_wdata[DATA_W*i +: DATA_W];
            active[i]    = is_active_cmd(cmd_arr[i]);
        end
    end

    logic [IDX_W-1:0] pick_idx;
    logic             any_req;

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  id_q, id_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req_i     (active),
        .rr_ptr_i  (ptr_q),
        .grant_o   (pick_idx),
        .any_req_o (any_req)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        terr_d  = terr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    id_d    = pick_idx;
                    cmd_d   = mem_cmd_t'(cmd_arr[pick_idx]);
                    addr_d  = addr_arr[pick_idx];
                    wdata_d = wdata_arr[pick_idx];
                    state_d = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                // mem_done wins over a timeout landing in the same cycle.
                if (mem_done) begin
                    if (cmd_q == MEM_LOAD) begin
                        rdata_d = mem_rdata;
                    end
                    ptr_d   = id_q;
                    state_d = DONE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    rdata_d = '0;
                    terr_d  = 1'b1;
                    ptr_d   = id_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset also restores rr_ptr so the first grant after reset goes to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            cmd_q   <= MEM_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
`endif
        end
    end

    always_comb begin
        req_done = '0;
        if (state_q == DONE) begin
            req_done[id_q] = 1'b1;
        end
    end

    assign mem_cmd     = (state_q == BUSY) ? cmd_q : MEM_IDLE;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign req_rdata   = rdata_q;
    assign grant_valid = (state_q == BUSY);
    assign grant_id    = id_q;

`ifdef MEM_ARB_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter and sequencer that shares the single load/store memory port among `NUM_REQ` instruction units. Each unit presents a load or store command. The arbiter picks one, drives the memory port, waits for `mem_done`, and returns a one-cycle completion pulse plus read data. It sits between the `iu` instances and the memory model, replacing their direct `mem_fetch_*` connections.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ADDR_W`, 11: memory address width.
- `DATA_W`, 8: data width.
- `TIMEOUT_CYC`, 64: BUSY cycles before abort (used only when the timeout feature is compiled in).

Ports, clock and reset first:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_cmd` in 2*NUM_REQ: per-requester command: 00 idle, 01 load, 10 store, 11 treated as idle.
- `req_addr` in ADDR_W*NUM_REQ: per-requester address.
- `req_wdata` in DATA_W*NUM_REQ: per-requester store data.
- `req_done` out NUM_REQ: one-hot completion pulse.
- `req_rdata` out DATA_W: broadcast load data, valid when `req_done` is high.
- `mem_cmd` out 2: memory command (00/01/10).
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory store data.
- `mem_rdata` in DATA_W: memory load data.
- `mem_done` in 1: memory completion.
- `grant_valid` out 1: a transaction is in progress (BUSY).
- `grant_id` out $clog2(NUM_REQ): requester currently or last granted.
- `timeout_err` out 1: sticky timeout flag.

## Operation
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - If any `req_cmd` is 01 or 10, choose the first requesting index scanning from `rr_ptr+1` mod NUM_REQ upward.
  - Latch that requester's id, cmd, addr and wdata, then go to BUSY.
  - If there is no request, stay in IDLE.
- BUSY:
  - `mem_cmd`, `mem_addr` and `mem_wdata` are driven from the latched registers and held constant; `grant_valid`=1.
  - On a cycle with `mem_done`=1:
    - a load captures `mem_rdata` into `req_rdata`;
    - a store leaves `req_rdata` unchanged;
    - `rr_ptr` is set to the granted id;
    - the FSM goes to DONE.
- DONE:
  - `req_done[id]`=1 for exactly this cycle; `mem_cmd`=00.
  - All requests are ignored; the FSM goes to IDLE.
  - The requester must update or drop `req_cmd` by the end of this cycle.
- Requesters hold `req_cmd`, `req_addr` and `req_wdata` stable from assertion until their `req_done`. Changes made after the grant are ignored because the values are latched.
- `mem_done` in IDLE or DONE is ignored.
- Reset values:
  - FSM in IDLE; `rr_ptr`=NUM_REQ-1, so the first grant goes to requester 0.
  - All outputs are 0: `mem_cmd`, `mem_addr`, `mem_wdata`, `req_done`, `req_rdata`, `grant_valid`, `grant_id`, `timeout_err`.
- Reset mid-transaction aborts the transfer: the FSM is in IDLE after the edge, `mem_cmd`=00, no `req_done` is issued for the aborted request, and `rr_ptr` is restored to its reset value.

## Timing
- The request is sampled at edge k in IDLE. `mem_cmd` is valid from cycle k+1, which is BUSY.
- If `mem_done` is high in the first BUSY cycle, DONE follows at k+2 and IDLE at k+3.
- Minimum transaction is 3 cycles. Back-to-back throughput is one transfer per 3 cycles plus memory latency.
- `mem_cmd` stays high for exactly the number of BUSY cycles and drops to 00 in the DONE cycle.
- With all requesters continuously active, grants rotate 0,1,2,...,NUM_REQ-1,0.
- No requester waits more than NUM_REQ-1 other transactions.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A BUSY cycle counter runs, cleared on entry to BUSY.
  - After TIMEOUT_CYC BUSY cycles without `mem_done`, the FSM goes to DONE and `req_done[id]` pulses with `req_rdata`=0.
  - `timeout_err` is set to 1 and cleared only by reset.
  - A `mem_done` arriving in the same cycle as the timeout takes precedence; it counts as a normal completion with no error.
- `MEM_ARB_TIMEOUT_EN` undefined: no counter, `timeout_err` is tied to 0, and BUSY waits indefinitely.

## Structure
- Shared package contents:
  - `mem_cmd_t` enum: MEM_IDLE=2'b00, MEM_LOAD=2'b01, MEM_STORE=2'b10. Its encoding matches the `iu` load/store op types.
  - `arb_state_t` enum: IDLE, BUSY, DONE.
  - Default width constants for ADDR_W and DATA_W.
- Sub-module `rr_picker`: combinational round-robin pick. Inputs are the request vector and `rr_ptr`; outputs are the granted index and an any-request flag. It is separately unit-testable.

## Test plan
- Single load: requester 2 loads from address 11'h155, memory returns 8'hA5 with `mem_done` on the 3rd BUSY cycle. Expect `mem_cmd`=01 and `mem_addr`=155 for 3 cycles, then `req_done`=4'b0100 for one cycle with `req_rdata`=A5.
- Single store: requester 0 stores 8'h3C to 11'h7FF. Expect `mem_cmd`=10 and `mem_wdata`=3C, `req_done`=4'b0001, and `req_rdata` keeping its previous value.
- All four requesters assert loads together, with memory completing in the first BUSY cycle. Expect grants in the order 0,1,2,3, `req_done` pulses 3 cycles apart, and `grant_id` matching each grant.
- Requesters 1 and 3 re-request continuously. Expect grants to alternate 1,3,1,3 with no starvation.
- Timeout with `MEM_ARB_TIMEOUT_EN` and TIMEOUT_CYC=8, `mem_done` never asserted. Expect 8 BUSY cycles, then a `req_done` pulse with `req_rdata`=00 and `timeout_err`=1 (sticky). Without the macro, BUSY persists past 100 cycles.
- Reset mid-BUSY: assert `rst_n`=0 for one cycle. Expect `mem_cmd`=00 and `grant_valid`=0 on the next cycle, no `req_done`, and the next grant going to requester 0.
